// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with a programmable
//               wait latency, byte-lane stores and misalign/range error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        cool_q, cool_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             acc_write;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wstrb;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_we;

  // The cycle right after a response handshake is spent idle without
  // accepting, so back-to-back requests are spaced by one dead cycle.
  assign req_ready = (state_q == ST_IDLE) && !cool_q && !reset;
  assign accept    = req_valid && req_ready;

  // With zero wait cycles the memory access happens on the accept edge,
  // so the operands come straight from the request port in that case.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
  assign acc_idx = acc_addr[IDX_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    cool_d     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          error_d = 1'b0;
          cool_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      error_d = acc_err;
      rdata_d = (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      cool_q  <= cool_d;
    end
  end

  // Storage is never cleared; reset only blocks an uncommitted store.
  assign mem_we = enter_resp && acc_write && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (WAIT_CYCLES 1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with one wait cycle
  logic        reset, req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  // Instance with zero wait cycles
  logic        reset0, req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_wstrb0;
  logic        rsp_valid0, rsp_ready0, rsp_error0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  logic [32:0] mon_e;
  logic [32:0] mon0_e;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Response monitors: pop expected entry on every handshake
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual rdata=%0h error=%0b required no response",
                 rsp_rdata, rsp_error);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[31:0]));
        chk("rsp_error", 64'(rsp_error), 64'(mon_e[32]));
      end
    end else if (rsp_valid === 1'b0) begin
      chk("idle_outputs_zero", 64'({rsp_error, rsp_rdata}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid0 === 1'b1 && rsp_ready0 === 1'b1) begin
      if (exp0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp0 actual rdata=%0h error=%0b required no response",
                 rsp_rdata0, rsp_error0);
      end else begin
        mon0_e = exp0_q.pop_front();
        chk("rsp0_rdata", 64'(rsp_rdata0), 64'(mon0_e[31:0]));
        chk("rsp0_error", 64'(rsp_error0), 64'(mon0_e[32]));
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    int t;
    int lat;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    rsp_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~wdata;
    req_wstrb = 4'hF;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("accept_to_valid_latency", 64'(lat), 64'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc;
    int last;
    reset = 1'b1;      reset0 = 1'b1;
    req_valid = 1'b0;  req_valid0 = 1'b0;
    req_write = 1'b0;  req_write0 = 1'b0;
    req_addr = '0;     req_addr0 = '0;
    req_wdata = '0;    req_wdata0 = '0;
    req_wstrb = '0;    req_wstrb0 = '0;
    rsp_ready = 1'b1;  rsp_ready0 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'({rsp_error, rsp_rdata}), 64'd0);
    chk("reset_req_ready0", 64'(req_ready0), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset0 = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Basic store/load, byte strobes, no-op store
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 32'h10, 32'h11223344, 4'h5, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);

    // Error cases leave memory untouched
    do_req(1'b1, 32'hFC, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    do_req(1'b1, 32'h00, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'hFC, 32'h0, 4'h0, 32'hAABBCCDD, 1'b0);
    do_req(1'b0, 32'h00, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    // Backpressure with the next request already waiting on the port
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    @(negedge clk);
    chk("bp_accept_ready", 64'(req_ready), 64'd1);
    exp_q.push_back({1'b0, 32'hDE22BE44});
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_wdata = 32'h0;
    req_wstrb = 4'hF;
    exp_q.push_back({1'b0, 32'h0});
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'hDE22BE44);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_hs_dead_cycle", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("post_hs_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    // Reset during WAIT aborts an uncommitted store
    do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_wstrb = 4'hF;
    @(negedge clk);
    chk("abort_accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_rsp_valid2", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 64'(req_ready), 64'd1);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Zero-wait instance: one-cycle latency and 3-cycle back-to-back cadence
    @(posedge clk);
    #1;
    req_valid0 = 1'b1;
    req_write0 = 1'b1;
    req_addr0  = 32'h8;
    req_wdata0 = 32'h55AA55AA;
    req_wstrb0 = 4'hF;
    @(negedge clk);
    chk("w0_store_ready", 64'(req_ready0), 64'd1);
    exp0_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("w0_latency", 64'(rsp_valid0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    req_valid0 = 1'b1;
    req_write0 = 1'b0;
    req_addr0  = 32'h8;
    acc = 0;
    last = 0;
    t = 0;
    while (acc < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (rsp_valid0) chk("w0_rsp_latency", 64'(t - last), 64'd1);
      if (req_ready0) begin
        if (acc > 0) chk("w0_cadence", 64'(t - last), 64'd3);
        last = t;
        acc++;
        exp0_q.push_back({1'b0, 32'h55AA55AA});
      end
    end
    chk("w0_accepts", 64'(acc), 64'd3);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("queue0_drained", 64'(exp0_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, memory size in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between request accept and response (0..15).
REQ-003 SHALL use reset reset, synchronous, active-high, and clock clk; all state updates on posedge clk.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  store byte enables, bit n -> byte lane n (bits 8n+7:8n).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  CPU can take the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_error  output  1  access was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request max.
REQ-017 req_ready SHALL be 1 only in IDLE and never while reset is high.
REQ-018 Request accepted when req_valid && req_ready; write, addr, wdata, wstrb SHALL be latched that cycle.
REQ-019 On accept: WAIT_CYCLES = 0 -> RESP next cycle; else -> WAIT, counter loaded with WAIT_CYCLES.
REQ-020 In WAIT, counter SHALL decrement each cycle; on the cycle it reaches 1 the FSM moves to RESP.
REQ-021 Accept-to-rsp_valid latency SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-022 Memory access (write commit, read sample) SHALL occur on the clock edge that enters RESP.
REQ-023 Error SHALL be flagged when req_addr[1:0] != 0 or req_addr >= 4*DEPTH_WORDS; on error no memory byte changes and rsp_rdata = 0.
REQ-024 Store SHALL update only bytes whose wstrb bit is 1; wstrb = 0 is a legal no-op store, no error.
REQ-025 Load SHALL return the full 32-bit word at addr[.:2] irrespective of wstrb.
REQ-026 In RESP, rsp_valid, rsp_rdata, rsp_error SHALL hold stable until rsp_valid && rsp_ready.
REQ-027 On response handshake FSM SHALL go to IDLE; a new request SHALL NOT be accepted in that same cycle (min 1 IDLE cycle).
REQ-028 Outside RESP, rsp_valid, rsp_rdata, rsp_error SHALL be 0.
REQ-029 A load accepted after a store's response handshake SHALL observe that store's data.
REQ-030 Input changes on req_* while not in IDLE SHALL have no effect.

Reset
REQ-031 On reset: FSM -> IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, req_ready 0 during reset cycle.
REQ-032 Reset mid-WAIT or mid-RESP SHALL abort the transaction; a store not yet committed SHALL NOT be written; no response is issued.
REQ-033 Memory contents SHALL NOT be cleared by reset; reads of never-written words are undefined and not checked.

Verification
REQ-034 WAIT_CYCLES=1: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, rsp_ready=1 -> rsp_valid 2 cycles after accept, rdata 0, error 0; then load 0x10 -> rdata 0xDEADBEEF.
REQ-035 Byte strobes: after 0xDEADBEEF at 0x10, store 0x11223344 wstrb 0x5 -> load 0x10 returns 0xDE22BE44.
REQ-036 Errors: load 0x12 -> error 1, rdata 0; store to 0x100 (DEPTH 64) -> error 1, and load 0xFC afterwards unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready 0 throughout; handshake then IDLE one cycle before next accept.
REQ-038 WAIT_CYCLES=0 build: accept -> rsp_valid next cycle; back-to-back loads with req_valid held high accepted every 3 cycles.
REQ-039 Reset during WAIT of a store to 0x20 (prior content 0x12345678) -> no rsp_valid, req_ready 1 after reset deasserts, load 0x20 returns 0x12345678.
